// File: rtl/frame_tx_arbiter.sv
// frame_tx_arbiter: round-robin arbiter that serialises one requester's frame
// (start, port, length, data, stop) onto a single line.
module frame_tx_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        clkEn,
    input  logic [3:0]  req,
    input  logic [15:0] lenIn,
    input  logic [3:0]  dataIn,
    output logic [3:0]  gnt,
    output logic [3:0]  dataTake,
    output logic        serOut,
    output logic        busy,
    output logic        Done
);
    typedef enum logic [2:0] {IDLE, START, PORT, LEN, DATA, STOP} state_t;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d, len_q, len_d, gnt_q, gnt_d;
    logic [1:0] idx_q, idx_d, ptr_q, ptr_d, win, c;
    logic       ser_q, ser_d, take;
    always_comb begin
        win = ptr_q;
        c   = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            c = ptr_q + 2'(k);
            if (req[c]) win = c;
        end
    end
    // data is consumed on the edge that leaves the last length bit and on every data edge but the last
    assign take     = clkEn && ((state_q == LEN && cnt_q == 4'd3 && len_q != 4'd0) ||
                                (state_q == DATA && cnt_q != len_q - 4'd1));
    assign dataTake = take ? gnt_q : 4'b0;
    assign gnt      = gnt_q;
    assign serOut   = ser_q;
    assign busy     = state_q != IDLE;
    assign Done     = state_q == STOP;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        ser_d   = ser_q;
        case (state_q)
            IDLE: if (|req) begin
                state_d = START;
                idx_d   = win;
                len_d   = lenIn[{win, 2'b00} +: 4];
                gnt_d   = 4'b1 << win;
                ptr_d   = win + 2'd1;
                cnt_d   = 4'd0;
                ser_d   = 1'b0;
            end
            START: begin
                state_d = PORT;
                cnt_d   = 4'd0;
                ser_d   = idx_q[1];
            end
            PORT: if (cnt_q == 4'd0) begin
                cnt_d = 4'd1;
                ser_d = idx_q[0];
            end else begin
                state_d = LEN;
                cnt_d   = 4'd0;
                ser_d   = len_q[3];
            end
            LEN: if (cnt_q != 4'd3) begin
                cnt_d = cnt_q + 4'd1;
                ser_d = len_q[2'd2 - cnt_q[1:0]];
            end else if (len_q != 4'd0) begin
                state_d = DATA;
                cnt_d   = 4'd0;
                ser_d   = dataIn[idx_q];
            end else begin
                state_d = STOP;
                ser_d   = 1'b1;
            end
            DATA: if (cnt_q != len_q - 4'd1) begin
                cnt_d = cnt_q + 4'd1;
                ser_d = dataIn[idx_q];
            end else begin
                state_d = STOP;
                ser_d   = 1'b1;
            end
            STOP: begin
                state_d = IDLE;
                gnt_d   = 4'b0;
                ser_d   = 1'b1;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0;
                ser_d   = 1'b1;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            len_q   <= 4'd0;
            gnt_q   <= 4'b0;
            idx_q   <= 2'd0;
            ptr_q   <= 2'd0;
            ser_q   <= 1'b1;
        end else if (clkEn) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            ser_q   <= ser_d;
        end
    end
endmodule

// File: doc/frame_tx_arbiter.md
FRAME_TX_ARBITER -- requirements
Module: frame_tx_arbiter

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset, with ports named clk and rst as elsewhere in the codebase.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-low reset, sampled on clk rising edge, overrides clkEn.
REQ-004 clkEn  input  1  advance qualifier; state, counters and registered outputs change only on rising edges with clkEn=1 ("enabled edge").
REQ-005 req  input  4  per-requester frame request, level.
REQ-006 lenIn  input  16  per-requester data length; requester i on bits [4i+3:4i], range 0..15.
REQ-007 dataIn  input  4  per-requester current data bit; bit i belongs to requester i.
REQ-008 gnt  output  4  one-hot grant, registered; all zero when no frame is in progress.
REQ-009 dataTake  output  4  combinational; bit i high when the next enabled edge consumes dataIn[i].
REQ-010 serOut  output  1  registered serial line; idle level 1.
REQ-011 busy  output  1  high in every state except Idle.
REQ-012 Done  output  1  high during the Stop state.

Function
REQ-013 Frame format on serOut, one bit per enabled edge: start bit 0, port index 2 bits MSB first, length 4 bits MSB first, then length data bits, then one stop bit 1.
REQ-014 States: Idle, Start, Port, Len, Data, Stop; the state names the bit currently on serOut.
REQ-015 Idle: serOut=1; if req!=0, the next enabled edge latches the winner index and its lenIn nibble, sets gnt, drives serOut to 0 and enters Start.
REQ-016 Start -> Port; Port holds 2 enabled edges -> Len; Len holds 4 enabled edges -> Data if latched length>0, else -> Stop.
REQ-017 Data holds exactly L enabled edges, where L is the latched length -> Stop.
REQ-018 Stop: serOut=1, Done=1; next enabled edge -> Idle, gnt cleared.
REQ-019 Arbitration: round-robin; the pointer resets to 0; search order is pointer, pointer+1, ... mod 4; after granting i, pointer = (i+1) mod 4.
REQ-020 Arbitration occurs only in Idle; req changes during a frame are ignored, and a dropped req does not abort the frame in progress.
REQ-021 Length and port are latched at grant; later lenIn changes have no effect on the current frame.
REQ-022 dataTake[g] = clkEn AND (state=Len at last length bit with L>0, OR state=Data before the last data bit), where g is the granted index; all other bits are 0.
REQ-023 Each data bit loaded into serOut is dataIn[g] sampled at the consuming edge.
REQ-024 Minimum spacing between frames: Stop plus one Idle cycle; a frame of length L occupies 8+L enabled edges from Start to Stop inclusive.
REQ-025 While clkEn=0, all state and outputs hold; dataTake is 0.

Reset
REQ-026 On rst=0 at an enabled or non-enabled edge, the module SHALL enter Idle with serOut=1, gnt=0, busy=0, Done=0, RR pointer=0, counters=0 and latched length=0.
REQ-027 Reset mid-frame SHALL abandon the frame immediately, with no stop bit emitted, and serOut returns to 1 on the reset edge.

Verification
REQ-028 req=0001, lenIn[3:0]=3, data bits 1,0,1, clkEn=1 -> serOut sequence 0,00,0011,101,1; Done high for 1 cycle; dataTake[0] high for 3 cycles.
REQ-029 req=1111 held across four frames, all lengths 0 -> grants in order 0,1,2,3, each frame 0,pp,0000,1.
REQ-030 req=0100 with length 15, lenIn changed to 2 mid-frame -> 15 data bits sent; gnt=0100 throughout.
REQ-031 clkEn toggling 1,0 pattern during a length-5 frame -> identical bit sequence, each bit held 2 cycles; dataTake only in clkEn=1 cycles.
REQ-032 rst=0 asserted in Data at bit 2 of 6 -> next cycle serOut=1, gnt=0, busy=0; following grant starts from requester 0.
REQ-033 req=1010 after a grant to 1 -> next grant goes to 3, then to 1.
